// File: rtl/dc_bridge_pkg.sv
// Shared definitions for the DDR cache-line bridge: app command codes, FSM encoding,
// read-timeout limit and the poison pattern returned when a read times out.
package dc_bridge_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_DONE = 3'd2,
    ST_RD_CMD  = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_t;

  localparam int unsigned    TOCNT_W          = 16;
  localparam int unsigned    RD_TIMEOUT_LIMIT = 65535;
  localparam logic [127:0]   POISON_DATA      = {4{32'hDEAD_BEEF}};

endpackage

// File: rtl/dc_mem_bridge_if.sv
// App-side bus of the DDR memory controller (command, write-data and read-data channels).
// master = bridge side, slave = memory-controller side.
interface dc_mem_bridge_if #(
  parameter int AWIDTH = 28
);
  logic [AWIDTH-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [127:0]      app_wdf_data;
  logic [15:0]       app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [127:0]      app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/dc_bridge_tocnt.sv
// Read-wait cycle counter; expired is high on the final allowed cycle of RD_WAIT.
// Only instantiated when DC_BRIDGE_RD_TIMEOUT_EN is defined.
module dc_bridge_tocnt
  import dc_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expired
);
  logic [TOCNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end else begin
      count_reg <= '0;
    end
  end

  assign expired = en && (count_reg == TOCNT_W'(RD_TIMEOUT_LIMIT - 1));
endmodule

// File: rtl/dc_mem_bridge.sv
// Data-cache to DDR app-interface bridge: one write-back slot and one refill slot,
// one command outstanding at a time. Optional read timeout: DC_BRIDGE_RD_TIMEOUT_EN.
module dc_mem_bridge
  import dc_bridge_pkg::*;
#(
  parameter int AWIDTH = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_calib_complete,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  input  logic         rqfull_1,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic         rd_timeout_err,
  dc_mem_bridge_if.master app
);
  state_t            state_reg;
  logic              wr_pend_reg, rd_pend_reg;
  logic [AWIDTH:4]   wr_addr_reg, rd_addr_reg;
  logic [15:0]       wr_mask_reg;
  logic [127:0]      wr_data_reg;

  logic [AWIDTH-1:0] app_addr_reg;
  logic [2:0]        app_cmd_reg;
  logic              app_en_reg;
  logic [127:0]      wdf_data_reg;
  logic [15:0]       wdf_mask_reg;
  logic              wdf_wren_reg;
  logic              cmd_done_reg, data_done_reg;
  logic              finish_wresp_reg, rdat_valid_reg, finish_mrd_reg, timeout_err_reg;
  logic [127:0]      rdat_reg;

  logic cmd_hs, data_hs, to_expired;

  assign cmd_hs  = app_en_reg & app.app_rdy;
  assign data_hs = wdf_wren_reg & app.app_wdf_rdy;

  // Line offset and bits above the DDR address range are dropped by the address mapping.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dcw_in_addr[31:AWIDTH+1], dcw_in_addr[3:0],
                              dcr_rin_addr[31:AWIDTH+1], dcr_rin_addr[3:0]};

`ifdef DC_BRIDGE_RD_TIMEOUT_EN
  dc_bridge_tocnt u_tocnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_reg == ST_RD_WAIT),
    .expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      wr_pend_reg      <= 1'b0;
      rd_pend_reg      <= 1'b0;
      wr_addr_reg      <= '0;
      rd_addr_reg      <= '0;
      wr_mask_reg      <= '0;
      wr_data_reg      <= '0;
      app_addr_reg     <= '0;
      app_cmd_reg      <= '0;
      app_en_reg       <= 1'b0;
      wdf_data_reg     <= '0;
      wdf_mask_reg     <= '0;
      wdf_wren_reg     <= 1'b0;
      cmd_done_reg     <= 1'b0;
      data_done_reg    <= 1'b0;
      finish_wresp_reg <= 1'b0;
      rdat_valid_reg   <= 1'b0;
      finish_mrd_reg   <= 1'b0;
      timeout_err_reg  <= 1'b0;
      rdat_reg         <= '0;
    end else begin
      finish_wresp_reg <= 1'b0;
      rdat_valid_reg   <= 1'b0;
      finish_mrd_reg   <= 1'b0;

      if (dcw_start_rq && !wr_pend_reg) begin
        wr_pend_reg <= 1'b1;
        wr_addr_reg <= dcw_in_addr[AWIDTH:4];
        wr_mask_reg <= dcw_in_mask;
        wr_data_reg <= dcw_in_data;
      end
      if (dcr_start_rq && !rd_pend_reg) begin
        rd_pend_reg <= 1'b1;
        rd_addr_reg <= dcr_rin_addr[AWIDTH:4];
      end

      case (state_reg)
        ST_IDLE: begin
          if (init_calib_complete) begin
            if (wr_pend_reg) begin
              state_reg     <= ST_WR;
              app_en_reg    <= 1'b1;
              app_cmd_reg   <= CMD_WRITE;
              app_addr_reg  <= {wr_addr_reg, 3'b000};
              wdf_data_reg  <= wr_data_reg;
              wdf_mask_reg  <= ~wr_mask_reg;
              wdf_wren_reg  <= 1'b1;
              cmd_done_reg  <= 1'b0;
              data_done_reg <= 1'b0;
            end else if (rd_pend_reg && !rqfull_1) begin
              state_reg    <= ST_RD_CMD;
              app_en_reg   <= 1'b1;
              app_cmd_reg  <= CMD_READ;
              app_addr_reg <= {rd_addr_reg, 3'b000};
            end
          end
        end
        ST_WR: begin
          // Command and data channels complete independently, in either order.
          if (cmd_hs) begin
            app_en_reg   <= 1'b0;
            cmd_done_reg <= 1'b1;
          end
          if (data_hs) begin
            wdf_wren_reg  <= 1'b0;
            data_done_reg <= 1'b1;
          end
          if ((cmd_done_reg || cmd_hs) && (data_done_reg || data_hs)) begin
            state_reg        <= ST_WR_DONE;
            finish_wresp_reg <= 1'b1;
          end
        end
        ST_WR_DONE: begin
          wr_pend_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
        ST_RD_CMD: begin
          if (cmd_hs) begin
            app_en_reg <= 1'b0;
            state_reg  <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (app.app_rd_data_valid) begin
            rdat_reg       <= app.app_rd_data;
            rdat_valid_reg <= 1'b1;
            finish_mrd_reg <= 1'b1;
            rd_pend_reg    <= 1'b0;
            state_reg      <= ST_IDLE;
          end else if (to_expired) begin
            rdat_reg        <= POISON_DATA;
            rdat_valid_reg  <= 1'b1;
            finish_mrd_reg  <= 1'b1;
            timeout_err_reg <= 1'b1;
            rd_pend_reg     <= 1'b0;
            state_reg       <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign app.app_addr     = app_addr_reg;
  assign app.app_cmd      = app_cmd_reg;
  assign app.app_en       = app_en_reg;
  assign app.app_wdf_data = wdf_data_reg;
  assign app.app_wdf_mask = wdf_mask_reg;
  assign app.app_wdf_wren = wdf_wren_reg;
  assign app.app_wdf_end  = wdf_wren_reg;

  assign dcw_finish_wresp = finish_wresp_reg;
  assign rdat_m_data      = rdat_reg;
  assign rdat_m_valid     = rdat_valid_reg;
  assign finish_mrd       = finish_mrd_reg;
`ifdef DC_BRIDGE_RD_TIMEOUT_EN
  assign rd_timeout_err   = timeout_err_reg;
`else
  assign rd_timeout_err   = 1'b0;
  logic unused_err;
  assign unused_err = timeout_err_reg;
`endif
endmodule

// File: tb/tb_dc_mem_bridge.sv
// Directed bench for dc_mem_bridge: inputs driven after the falling edge, outputs
// sampled on the falling edge, expected values hand-computed per step.
module tb_dc_mem_bridge;
  import dc_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         init_calib_complete;
  logic         dcw_start_rq;
  logic [31:0]  dcw_in_addr;
  logic [15:0]  dcw_in_mask;
  logic [127:0] dcw_in_data;
  logic         dcw_finish_wresp;
  logic         dcr_start_rq;
  logic [31:0]  dcr_rin_addr;
  logic         rqfull_1;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid;
  logic         finish_mrd;
  logic         rd_timeout_err;

  int total = 0;
  int bad   = 0;

  dc_mem_bridge_if #(.AWIDTH(28)) app_bus ();

  dc_mem_bridge #(.AWIDTH(28)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .dcw_start_rq        (dcw_start_rq),
    .dcw_in_addr         (dcw_in_addr),
    .dcw_in_mask         (dcw_in_mask),
    .dcw_in_data         (dcw_in_data),
    .dcw_finish_wresp    (dcw_finish_wresp),
    .dcr_start_rq        (dcr_start_rq),
    .dcr_rin_addr        (dcr_rin_addr),
    .rqfull_1            (rqfull_1),
    .rdat_m_data         (rdat_m_data),
    .rdat_m_valid        (rdat_m_valid),
    .finish_mrd          (finish_mrd),
    .rd_timeout_err      (rd_timeout_err),
    .app                 (app_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic seen;

  initial begin
    rst_n = 1'b0;
    init_calib_complete = 1'b0;
    dcw_start_rq = 1'b0; dcw_in_addr = '0; dcw_in_mask = '0; dcw_in_data = '0;
    dcr_start_rq = 1'b0; dcr_rin_addr = '0; rqfull_1 = 1'b0;
    app_bus.app_rdy = 1'b0; app_bus.app_wdf_rdy = 1'b0;
    app_bus.app_rd_data = '0; app_bus.app_rd_data_valid = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_app_en", app_bus.app_en, 0);
    chk("rst_app_addr", app_bus.app_addr, 0);
    chk("rst_wdf_wren", app_bus.app_wdf_wren, 0);
    chk("rst_wdf_mask", app_bus.app_wdf_mask, 0);
    chk("rst_rdat", rdat_m_data, 0);
    chk("rst_flags", {dcw_finish_wresp, rdat_m_valid, finish_mrd, rd_timeout_err}, 0);
    $display("txn reset checked");
    rst_n = 1'b1;
    init_calib_complete = 1'b1;
    app_bus.app_rdy = 1'b1; app_bus.app_wdf_rdy = 1'b1;
    step();

    // Basic write: 0x1230 -> app_addr 0x918, mask 0x00FF -> wdf mask 0xFF00
    dcw_start_rq = 1'b1; dcw_in_addr = 32'h0000_1230; dcw_in_mask = 16'h00FF;
    dcw_in_data = {4{32'h1234_5678}};
    step(); dcw_start_rq = 1'b0;
    chk("wr_idle_en", app_bus.app_en, 0);
    step();
    chk("wr_en", app_bus.app_en, 1);
    chk("wr_cmd", app_bus.app_cmd, 3'b000);
    chk("wr_addr", app_bus.app_addr, 28'h918);
    chk("wr_mask", app_bus.app_wdf_mask, 16'hFF00);
    chk("wr_data", app_bus.app_wdf_data, {4{32'h1234_5678}});
    chk("wr_wren_end", {app_bus.app_wdf_wren, app_bus.app_wdf_end}, 2'b11);
    chk("wr_fin_early", dcw_finish_wresp, 0);
    step();
    chk("wr_fin", dcw_finish_wresp, 1);
    chk("wr_en_drop", {app_bus.app_en, app_bus.app_wdf_wren}, 2'b00);
    step();
    chk("wr_fin_pulse", dcw_finish_wresp, 0);
    $display("txn write 0x1230 done");

    // Basic read: 0x40 -> app_addr 0x20, data after 20 cycles
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h40;
    step(); dcr_start_rq = 1'b0;
    step();
    chk("rd_en", app_bus.app_en, 1);
    chk("rd_cmd", app_bus.app_cmd, 3'b001);
    chk("rd_addr", app_bus.app_addr, 28'h20);
    step();
    chk("rd_en_drop", app_bus.app_en, 0);
    repeat (18) step();
    chk("rd_wait_valid", rdat_m_valid, 0);
    app_bus.app_rd_data = {16{8'hA5}}; app_bus.app_rd_data_valid = 1'b1;
    step();
    app_bus.app_rd_data_valid = 1'b0; app_bus.app_rd_data = {16{8'h11}};
    chk("rd_valid_fin", {rdat_m_valid, finish_mrd}, 2'b11);
    chk("rd_data", rdat_m_data, {16{8'hA5}});
    step();
    chk("rd_pulse", {rdat_m_valid, finish_mrd}, 2'b00);
    chk("rd_hold", rdat_m_data, {16{8'hA5}});
    $display("txn read 0x40 done");

    // Stray read-data valid in IDLE is ignored
    app_bus.app_rd_data_valid = 1'b1;
    step(); app_bus.app_rd_data_valid = 1'b0;
    step();
    chk("stray_valid", rdat_m_valid, 0);
    chk("stray_hold", rdat_m_data, {16{8'hA5}});
    $display("txn stray valid done");

    // Same-cycle write and read: write first
    dcw_start_rq = 1'b1; dcw_in_addr = 32'h2000; dcw_in_mask = 16'hFFFF; dcw_in_data = {4{32'hCAFE_0001}};
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h3000;
    step(); dcw_start_rq = 1'b0; dcr_start_rq = 1'b0;
    step();
    chk("both_wr_first", {app_bus.app_en, app_bus.app_cmd}, {1'b1, 3'b000});
    chk("both_wr_addr", app_bus.app_addr, 28'h1000);
    step();
    chk("both_wr_fin", dcw_finish_wresp, 1);
    step();
    chk("both_rd_not_yet", app_bus.app_en, 0);
    step();
    chk("both_rd_cmd", {app_bus.app_en, app_bus.app_cmd}, {1'b1, 3'b001});
    chk("both_rd_addr", app_bus.app_addr, 28'h1800);
    step();
    app_bus.app_rd_data = {4{32'h0BAD_F00D}}; app_bus.app_rd_data_valid = 1'b1;
    step(); app_bus.app_rd_data_valid = 1'b0;
    chk("both_rd_data", {rdat_m_valid, rdat_m_data}, {1'b1, {4{32'h0BAD_F00D}}});
    step();
    $display("txn same-cycle write+read done");

    // init_calib_complete low holds off the write
    init_calib_complete = 1'b0;
    dcw_start_rq = 1'b1; dcw_in_addr = 32'h50; dcw_in_mask = 16'h0F0F;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(); dcw_start_rq = 1'b0;
      seen = seen | app_bus.app_en;
    end
    chk("calib_hold", seen, 0);
    init_calib_complete = 1'b1;
    step();
    chk("calib_release", {app_bus.app_en, app_bus.app_cmd}, {1'b1, 3'b000});
    chk("calib_mask", app_bus.app_wdf_mask, 16'hF0F0);
    step();
    chk("calib_fin", dcw_finish_wresp, 1);
    step();
    $display("txn calib hold done");

    // rqfull_1 high holds off the read
    rqfull_1 = 1'b1;
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h80;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(); dcr_start_rq = 1'b0;
      seen = seen | app_bus.app_en;
    end
    chk("rqfull_hold", seen, 0);
    rqfull_1 = 1'b0;
    step();
    chk("rqfull_release", {app_bus.app_en, app_bus.app_cmd}, {1'b1, 3'b001});
    chk("rqfull_addr", app_bus.app_addr, 28'h40);
    step();
    app_bus.app_rd_data = {4{32'h7777_7777}}; app_bus.app_rd_data_valid = 1'b1;
    step(); app_bus.app_rd_data_valid = 1'b0;
    chk("rqfull_data", {finish_mrd, rdat_m_data}, {1'b1, {4{32'h7777_7777}}});
    step();
    $display("txn rqfull hold done");

    // Slow handshakes: data accepted first, completion after the command
    app_bus.app_rdy = 1'b0; app_bus.app_wdf_rdy = 1'b0;
    dcw_start_rq = 1'b1; dcw_in_addr = 32'h100; dcw_in_mask = 16'h0001;
    step(); dcw_start_rq = 1'b0;
    step();
    chk("slow_both_up", {app_bus.app_en, app_bus.app_wdf_wren}, 2'b11);
    repeat (2) step();
    app_bus.app_wdf_rdy = 1'b1;
    step();
    app_bus.app_wdf_rdy = 1'b0;
    chk("slow_data_acc", {app_bus.app_en, app_bus.app_wdf_wren, app_bus.app_wdf_end}, 3'b100);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | dcw_finish_wresp | app_bus.app_wdf_wren | ~app_bus.app_en;
    end
    chk("slow_wait_cmd", seen, 0);
    app_bus.app_rdy = 1'b1;
    step();
    chk("slow_fin", {dcw_finish_wresp, app_bus.app_en}, 2'b10);
    step();
    chk("slow_fin_pulse", dcw_finish_wresp, 0);
    app_bus.app_wdf_rdy = 1'b1;
    $display("txn slow handshake write done");

`ifdef DC_BRIDGE_RD_TIMEOUT_EN
    // Read with no data: poison after 65535 wait cycles
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h200;
    step(); dcr_start_rq = 1'b0;
    step();
    step();
    repeat (65534) step();
    chk("to_not_yet", {rdat_m_valid, rd_timeout_err}, 2'b00);
    step();
    chk("to_valid", {rdat_m_valid, finish_mrd, rd_timeout_err}, 3'b111);
    chk("to_data", rdat_m_data, {4{32'hDEAD_BEEF}});
    step();
    chk("to_sticky", {rdat_m_valid, rd_timeout_err}, 2'b01);
    $display("txn read timeout done");
`endif

    // Reset in the middle of RD_WAIT
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h300;
    step(); dcr_start_rq = 1'b0;
    step();
    chk("mid_rd_cmd", app_bus.app_en, 1);
    step();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdat", rdat_m_data, 0);
    chk("mid_rst_flags", {dcw_finish_wresp, rdat_m_valid, finish_mrd, rd_timeout_err}, 0);
    chk("mid_rst_app", {app_bus.app_en, app_bus.app_cmd, app_bus.app_addr}, 0);
    step();
    rst_n = 1'b1;
    app_bus.app_rd_data = {4{32'h5555_5555}}; app_bus.app_rd_data_valid = 1'b1;
    step(); app_bus.app_rd_data_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | rdat_m_valid | finish_mrd | app_bus.app_en;
    end
    chk("mid_rst_abandon", seen, 0);
    chk("mid_rst_data_zero", rdat_m_data, 0);
    $display("txn mid-read reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
